pipe_field: RTL and testbench

PIPE_FIELD -- requirements
Module: pipe_field

---
 rtl/pipe_field_pkg.sv | 44 ++++
 rtl/gap_lfsr.sv | 28 ++
 rtl/pipe_field.sv | 159 +++++++++++++++
 tb/tb_pipe_field.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_field_pkg.sv
// Shared game constants, pipe record type and gap reload helper
// for the scrolling pipe field.
package pipe_field_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Fibonacci form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic {
    ST_IDLE,
    ST_UPDATE
  } upd_state_t;

  typedef struct packed {
    logic [10:0] p;
    logic [8:0]  gap;
  } pipe_t;

  function automatic int pipe_total(int n, int s);
    return n * s;
  endfunction

  function automatic logic [8:0] gap_reload(
    logic [15:0] lfsr,
    int          gmin,
    int          gmax
  );
    logic [9:0] v;
    logic [9:0] g;
    int         span;
    span = gmax - gmin;
    v = {1'b0, lfsr[8:0]};
    if (int'(v) > span)
      v = v - 10'(span);
    g = 10'(gmin) + v;
    if (int'(g) > gmax)
      g = 10'(gmax);
    return g[8:0];
  endfunction

endpackage

// File: rtl/gap_lfsr.sv
// 16-bit Fibonacci LFSR that feeds gap heights.
// Steps once per update cycle; clear reloads the seed.
module gap_lfsr
  import pipe_field_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb    = ^(lfsr_q & LFSR_TAPS);
  assign value = lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lfsr_q <= LFSR_SEED;
    else if (clear)
      lfsr_q <= LFSR_SEED;
    else if (step)
      lfsr_q <= {fb, lfsr_q[15:1]};
  end

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe columns: pixel hit test, per-frame scroll FSM,
// score counting and sticky collision detection.
module pipe_field
  import pipe_field_pkg::*;
#(
  parameter int N_PIPES = 4,
  parameter int PIPE_W  = 50,
  parameter int SPACING = 200,
  parameter int GAP_H   = 100,
  parameter int GAP_MIN = 40,
  parameter int GAP_MAX = 340,
  parameter int SPEED   = 1,
  parameter int BIRD_X  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        run,
  input  logic        restart,
  input  logic [9:0]  px,
  input  logic [8:0]  py,
  input  logic        bird_px,
  output logic        pipe_px,
  output logic        game_over,
  output logic [15:0] score,
  output logic        update_busy,
  output logic        update_done
);

  localparam int TOTAL = pipe_total(N_PIPES, SPACING);
  localparam int IW = (N_PIPES > 1) ? $clog2(N_PIPES) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_PIPES - 1);

  if (TOTAL < SCREEN_W + PIPE_W) begin : g_bad_total
    $error("pipe loop shorter than screen plus pipe width");
  end
  if (GAP_MAX + GAP_H > SCREEN_H) begin : g_bad_gap
    $error("gap extends below the screen");
  end

  function automatic pipe_t init_pipe(int i);
    pipe_t r;
    r.p   = 11'((i + 1) * SPACING);
    r.gap = 9'(GAP_MIN);
    return r;
  endfunction

  upd_state_t    state_q, state_d;
  logic [IW-1:0] idx_q;
  pipe_t         pipes_q [N_PIPES];
  pipe_t         cur, nxt;
  logic [15:0]   lfsr_val;
  logic          bird_q;
  logic          hit;
  logic          start;
  logic          last;
  logic          passed;
  logic          pix_hit;

  assign start = (state_q == ST_IDLE) && frame_tick
                 && run && !game_over;
  assign last  = (idx_q == LAST);
  assign hit   = bird_q & pipe_px;
  assign update_busy = (state_q == ST_UPDATE);

  gap_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (restart),
    .step  (update_busy),
    .value (lfsr_val)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_UPDATE;
      ST_UPDATE: if (last)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (restart)
      state_d = ST_IDLE;
  end

  // Scroll of the pipe currently selected by idx_q
  always_comb begin
    cur = pipes_q[idx_q];
    nxt = cur;
    if (cur.p <= 11'(SPEED)) begin
      nxt.p   = cur.p + 11'(TOTAL - SPEED);
      nxt.gap = gap_reload(lfsr_val, GAP_MIN, GAP_MAX);
    end else begin
      nxt.p = cur.p - 11'(SPEED);
    end
    passed = (cur.p > 11'(BIRD_X))
             && (nxt.p <= 11'(BIRD_X));
  end

  always_comb begin
    logic [11:0] x;
    logic [11:0] r;
    logic [9:0]  y;
    logic [9:0]  g;
    pix_hit = 1'b0;
    x = {2'b0, px};
    y = {1'b0, py};
    for (int i = 0; i < N_PIPES; i++) begin
      r = {1'b0, pipes_q[i].p};
      g = {1'b0, pipes_q[i].gap};
      if (x < r && x + 12'(PIPE_W) >= r
          && (y < g || y >= g + 10'(GAP_H)))
        pix_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_PIPES; i++)
        pipes_q[i] <= init_pipe(i);
    end else if (restart) begin
      for (int i = 0; i < N_PIPES; i++)
        pipes_q[i] <= init_pipe(i);
    end else if (update_busy) begin
      pipes_q[idx_q] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      score       <= '0;
      game_over   <= 1'b0;
      update_done <= 1'b0;
      bird_q      <= 1'b0;
      pipe_px     <= 1'b0;
    end else if (restart) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      score       <= '0;
      game_over   <= 1'b0;
      update_done <= 1'b0;
      bird_q      <= 1'b0;
      pipe_px     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= (update_busy && !last)
                     ? idx_q + IW'(1) : '0;
      update_done <= update_busy && last;
      if (update_busy && passed)
        score <= score + 16'd1;
      if (hit)
        game_over <= 1'b1;
      bird_q      <= bird_px;
      pipe_px     <= pix_hit;
    end
  end

endmodule

// File: tb/tb_pipe_field.sv
// Scoreboard bench for pipe_field: pixel queries and per-update
// state are queued by the driver and checked by monitors.
module tb_pipe_field;

  localparam int N   = 4;
  localparam int SP  = 200;
  localparam int TOT = 800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic        restart = 1'b0;
  logic        bird_px = 1'b0;
  logic [9:0]  px = '0;
  logic [8:0]  py = '0;
  logic        pipe_px, game_over, update_busy, update_done;
  logic [15:0] score;

  logic        tick2 = 1'b0;
  logic        pipe_px2, go2, busy2, done2;
  logic [15:0] score2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_cyc = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_field dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .run(run), .restart(restart), .px(px), .py(py),
    .bird_px(bird_px), .pipe_px(pipe_px),
    .game_over(game_over), .score(score),
    .update_busy(update_busy), .update_done(update_done)
  );

  pipe_field #(.N_PIPES(8), .SPEED(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(tick2),
    .run(1'b1), .restart(1'b0), .px(px), .py(py),
    .bird_px(1'b0), .pipe_px(pipe_px2),
    .game_over(go2), .score(score2),
    .update_busy(busy2), .update_done(done2)
  );

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model
  int          mp [N];
  int          mg [N];
  int          ms;
  logic [15:0] ml;

  function automatic int model_gap(logic [15:0] l);
    int v;
    v = int'(l) % 512;
    if (v > 300) v = v - 300;
    return (40 + v > 340) ? 340 : 40 + v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mp[i] = (i + 1) * SP;
      mg[i] = 40;
    end
    ms = 0;
    ml = 16'hACE1;
  endfunction

  function automatic void model_update();
    int old;
    for (int i = 0; i < N; i++) begin
      old = mp[i];
      if (old <= 1) begin
        mp[i] = old + TOT - 1;
        mg[i] = model_gap(ml);
      end else begin
        mp[i] = old - 1;
      end
      if (old > 100 && mp[i] <= 100) ms = (ms + 1) % 65536;
      ml = {ml[0] ^ ml[2] ^ ml[3] ^ ml[5], ml[15:1]};
    end
  endfunction

  // Scoreboards
  typedef struct {
    int p0;
    int gap0;
    int score;
  } upd_t;

  bit   pix_exp_q [$];
  upd_t upd_q [$];
  logic qv = 1'b0;
  logic qv_d = 1'b0;

  always @(posedge clk) qv_d <= qv;

  always @(negedge clk) begin : mon_pix
    if (qv_d) begin
      if (pix_exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL pix_queue: got pipe_px=%0b with nothing expected",
                 pipe_px);
      end else begin
        chk("pipe_px", pipe_px, pix_exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_done
    upd_t e;
    if (update_done) begin
      done_cnt++;
      if (upd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: got pulse at cyc %0d expected none",
                 cyc);
      end else begin
        e = upd_q.pop_front();
        chk("upd_p0", dut.pipes_q[0].p, e.p0);
        chk("upd_gap0", dut.pipes_q[0].gap, e.gap0);
        chk("upd_score", score, e.score);
        chk("done_latency", cyc - tick_cyc, N + 1);
      end
    end
    if (done2) done2_cnt++;
  end

  task automatic query(int x, int y, bit e);
    @(negedge clk);
    px = 10'(x); py = 9'(y); qv = 1'b1;
    pix_exp_q.push_back(e);
    @(negedge clk);
    qv = 1'b0;
  endtask

  task automatic tick(bit exp_upd);
    @(negedge clk);
    frame_tick = 1'b1;
    tick_cyc = cyc;
    if (exp_upd) begin
      model_update();
      upd_q.push_back('{p0: mp[0], gap0: mg[0], score: ms});
    end
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_after_tick", update_busy, exp_upd);
    repeat (N + 2) @(negedge clk);
  endtask

  task automatic check_init(string tag);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_busy"}, update_busy, 0);
    chk({tag, "_done"}, update_done, 0);
    chk({tag, "_pipe_px"}, pipe_px, 0);
    chk({tag, "_lfsr"}, dut.u_lfsr.lfsr_q, 16'hACE1);
    chk({tag, "_p0"}, dut.pipes_q[0].p, 200);
    chk({tag, "_p1"}, dut.pipes_q[1].p, 400);
    chk({tag, "_p2"}, dut.pipes_q[2].p, 600);
    chk({tag, "_p3"}, dut.pipes_q[3].p, 800);
    chk({tag, "_gap0"}, dut.pipes_q[0].gap, 40);
    chk({tag, "_gap3"}, dut.pipes_q[3].gap, 40);
  endtask

  task automatic pixel_set();
    query(150, 10, 1'b1);
    query(150, 100, 1'b0);
    query(199, 10, 1'b1);
    query(200, 10, 1'b0);
    query(250, 200, 1'b0);
    query(390, 450, 1'b1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    model_reset();
    repeat (3) @(negedge clk);
    check_init("reset");
    rst_n = 1'b1;
    pixel_set();

    tick(1'b0);
    run = 1'b1;
    for (int k = 1; k <= 100; k++) tick(1'b1);
    chk("p0_at_100", dut.pipes_q[0].p, 100);
    chk("score_at_100", score, 1);
    chk("done_count_100", done_cnt, 100);

    for (int k = 101; k <= 199; k++) tick(1'b1);
    chk("p0_at_199", dut.pipes_q[0].p, 1);
    tick(1'b1);
    chk("p0_at_200", dut.pipes_q[0].p, 800);
    chk("gap0_in_range", (dut.pipes_q[0].gap >= 40)
        && (dut.pipes_q[0].gap <= 340), 1);
    chk("gap0_model", dut.pipes_q[0].gap, mg[0]);
    chk("score_at_200", score, 1);

    @(negedge clk);
    px = 10'd160; py = 9'd10; bird_px = 1'b1; qv = 1'b1;
    pix_exp_q.push_back(1'b1);
    @(negedge clk);
    bird_px = 1'b0; qv = 1'b0;
    chk("game_over_1clk", game_over, 0);
    @(negedge clk);
    chk("game_over_2clk", game_over, 1);
    repeat (3) tick(1'b0);
    chk("go_p0_held", dut.pipes_q[0].p, 800);
    chk("go_score_held", score, 1);
    chk("go_sticky", game_over, 1);
    chk("go_done_count", done_cnt, 200);

    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    model_reset();
    check_init("restart");
    for (int k = 0; k < 105; k++) tick(1'b1);
    chk("score_replay", score, 1);

    @(negedge clk);
    px = 10'd160; py = 9'd10;
    frame_tick = 1'b1; tick_cyc = cyc;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_before_abort", update_busy, 1);
    @(negedge clk);
    restart = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0; frame_tick = 1'b0;
    model_reset();
    check_init("abort");
    repeat (N + 4) @(negedge clk);
    chk("abort_no_done", done_cnt, 305);
    pixel_set();

    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    chk("d2_busy", busy2, 1);
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    repeat (14) @(negedge clk);
    chk("d2_p0", dut2.pipes_q[0].p, 197);
    chk("d2_p7", dut2.pipes_q[7].p, 1597);
    chk("d2_done_count", done2_cnt, 1);
    chk("d2_busy_end", busy2, 0);

    repeat (4) @(negedge clk);
    chk("pix_q_drained", pix_exp_q.size(), 0);
    chk("upd_q_drained", upd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
